sound_ch1_square: RTL and testbench

- Game Boy sound channel 1: square wave with frequency sweep, length counter and volume envelope.
- Registers NR10–NR14 sit on the IO-register bus. Produces a 4-bit unsigned sample per clock for the AC97 mixer/DAC path.
- Sits directly downstream of the IO-register write path and upstream of the channel mixer.
- Contains the 512 Hz frame sequencer that clocks the sweep, length and envelope units.

---
 rtl/sound_ch1_square_pkg.sv | 82 ++++++++
 rtl/sound_frame_sequencer.sv | 47 ++++
 rtl/sound_ch1_square.sv | 214 +++++++++++++++++++++
 tb/tb_sound_ch1_square.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/sound_ch1_square_pkg.sv
// rtl/sound_ch1_square_pkg.sv - shared sound-channel constants, duty table and arithmetic helpers
//
// Purpose : register addresses (NR10..NR14), duty waveform table, frame-step
//           enables and small helpers shared by the square channel and the
//           frame sequencer.
// Ports   : none (package).

package sound_ch1_square_pkg;

   localparam logic [15:0] NR10_ADDR = 16'hFF10;
   localparam logic [15:0] NR11_ADDR = 16'hFF11;
   localparam logic [15:0] NR12_ADDR = 16'hFF12;
   localparam logic [15:0] NR13_ADDR = 16'hFF13;
   localparam logic [15:0] NR14_ADDR = 16'hFF14;

   // Bit 7 of each entry is duty position 0.
   localparam logic [7:0] DUTY_TABLE [4] = '{
      8'b0000_0001,
      8'b1000_0001,
      8'b1000_0111,
      8'b0111_1110
   };

   // Bit n set = the unit is clocked on frame step n.
   localparam logic [7:0] LEN_STEPS   = 8'b0101_0101;
   localparam logic [7:0] SWEEP_STEPS = 8'b0100_0100;
   localparam logic [2:0] ENV_STEP    = 3'd7;

   typedef enum logic [2:0] {
      SEL_NONE,
      SEL_NR10,
      SEL_NR11,
      SEL_NR12,
      SEL_NR13,
      SEL_NR14
   } reg_sel_e;

   function automatic reg_sel_e reg_decode(input logic [15:0] addr);
      reg_sel_e sel;
      case (addr)
         NR10_ADDR: sel = SEL_NR10;
         NR11_ADDR: sel = SEL_NR11;
         NR12_ADDR: sel = SEL_NR12;
         NR13_ADDR: sel = SEL_NR13;
         NR14_ADDR: sel = SEL_NR14;
         default:   sel = SEL_NONE;
      endcase
      return sel;
   endfunction

   // Position p maps to bit 7-p, which for a 3-bit index is ~p.
   function automatic logic duty_level(input logic [1:0] duty, input logic [2:0] pos);
      logic [7:0] pat;
      pat = DUTY_TABLE[duty];
      return pat[~pos];
   endfunction

   // Frequency timer reload value: (2048 - freq) * 4 clocks, minus one because
   // the timer counts down to zero inclusive.
   function automatic logic [12:0] freq_reload(input logic [10:0] freq);
      logic [13:0] period;
      period = {12'd2048 - {1'b0, freq}, 2'b00};
      return 13'(period - 14'd1);
   endfunction

   // 12-bit sweep step so an add overflow past 2047 is visible in bit 11.
   function automatic logic [11:0] sweep_calc(input logic [10:0] shadow,
                                              input logic        negate,
                                              input logic [2:0]  shift);
      logic [11:0] base;
      logic [11:0] delta;
      base  = {1'b0, shadow};
      delta = base >> shift;
      return negate ? (base - delta) : (base + delta);
   endfunction

   // A sweep period of 0 still runs the timer, as if it were 8.
   function automatic logic [3:0] sweep_reload(input logic [2:0] period);
      return (period == 3'd0) ? 4'd8 : {1'b0, period};
   endfunction

endpackage

// File: rtl/sound_frame_sequencer.sv
// rtl/sound_frame_sequencer.sv - 512 Hz frame sequencer emitting length/sweep/envelope ticks
//
// Purpose : divides I_CLK by FS_DIV and walks a 3-bit step 0..7; emits a
//           one-cycle tick for each unit on the steps that clock it.
// Ports   : I_CLK, I_RESET_L (async, active low)
//           O_LEN_TICK   - length clock (steps 0,2,4,6)
//           O_SWEEP_TICK - sweep clock (steps 2,6)
//           O_ENV_TICK   - envelope clock (step 7)

module sound_frame_sequencer #(
   parameter int FS_DIV = 8192,
   parameter int FS_W   = 13
) (
   input  logic I_CLK,
   input  logic I_RESET_L,
   output logic O_LEN_TICK,
   output logic O_SWEEP_TICK,
   output logic O_ENV_TICK
);
   import sound_ch1_square_pkg::*;

   localparam logic [FS_W-1:0] DIV_LAST = FS_W'(FS_DIV - 1);

   logic [FS_W-1:0] div_ctr;
   logic [2:0]      step;
   logic            wrap;

   assign wrap = (div_ctr == DIV_LAST);

   always_ff @(posedge I_CLK or negedge I_RESET_L) begin
      if (!I_RESET_L) begin
         div_ctr <= '0;
         step    <= 3'd0;
      end else if (wrap) begin
         div_ctr <= '0;
         step    <= step + 3'd1;
      end else begin
         div_ctr <= div_ctr + FS_W'(1);
      end
   end

   // The tick belongs to the step that is ending on this wrap.
   assign O_LEN_TICK   = wrap & LEN_STEPS[step];
   assign O_SWEEP_TICK = wrap & SWEEP_STEPS[step];
   assign O_ENV_TICK   = wrap & (step == ENV_STEP);

endmodule

// File: rtl/sound_ch1_square.sv
// rtl/sound_ch1_square.sv - sound channel 1: square wave with sweep, length and envelope
//
// Purpose : NR10..NR14 register file, frequency timer / duty generator,
//           sweep, length and envelope units clocked by the frame sequencer.
// Ports   : I_CLK, I_RESET_L (async, active low)
//           I_IOREG_ADDR  - IO register address (FF10..FF14 decoded here)
//           IO_IOREG_DATA - register data; driven only during a channel read
//           I_IOREG_WE_L  - write strobe, active low
//           I_IOREG_RE_L  - read strobe, active low
//           O_CH1_SAMPLE  - 4-bit registered sample
//           O_CH1_ON      - channel enabled status

module sound_ch1_square #(
   parameter int FS_DIV = 8192,
   parameter int FS_W   = 13
) (
   input  logic        I_CLK,
   input  logic        I_RESET_L,
   input  logic [15:0] I_IOREG_ADDR,
   inout  wire  [7:0]  IO_IOREG_DATA,
   input  logic        I_IOREG_WE_L,
   input  logic        I_IOREG_RE_L,
   output logic [3:0]  O_CH1_SAMPLE,
   output logic        O_CH1_ON
);
   import sound_ch1_square_pkg::*;

   // Register fields
   logic [6:0]  nr10;          // sweep period[6:4], negate[3], shift[2:0]
   logic [1:0]  duty;
   logic [7:0]  nr12;          // initial vol[7:4], env dir[3], env period[2:0]
   logic [10:0] freq;
   logic        len_en;

   // Channel state
   logic [6:0]  length_ctr;    // 0..64
   logic [3:0]  volume;
   logic [2:0]  env_timer;
   logic [2:0]  duty_pos;
   logic [12:0] freq_timer;
   logic [10:0] shadow;
   logic [3:0]  sweep_timer;
   logic        sweep_en;
   logic        ch_on;
   logic [3:0]  sample;

   logic        len_tick;
   logic        sweep_tick;
   logic        env_tick;

   reg_sel_e    sel;
   logic [7:0]  wdata;
   logic [7:0]  rd_data;
   logic        wr_en;
   logic        rd_en;
   logic        trigger;
   logic        dac_en;
   logic [10:0] trig_freq;
   logic [11:0] sweep_new;
   logic [11:0] sweep_new2;
   logic [11:0] trig_sweep;

   sound_frame_sequencer #(
      .FS_DIV (FS_DIV),
      .FS_W   (FS_W)
   ) u_frame_seq (
      .I_CLK        (I_CLK),
      .I_RESET_L    (I_RESET_L),
      .O_LEN_TICK   (len_tick),
      .O_SWEEP_TICK (sweep_tick),
      .O_ENV_TICK   (env_tick)
   );

   assign sel     = reg_decode(I_IOREG_ADDR);
   assign wdata   = IO_IOREG_DATA;
   assign wr_en   = ~I_IOREG_WE_L;
   assign trigger = wr_en && (sel == SEL_NR14) && wdata[7];
   assign dac_en  = |nr12[7:3];

   // A trigger write carries the new high frequency bits, so the trigger
   // actions must see them rather than the stale register.
   assign trig_freq  = {wdata[2:0], freq[7:0]};
   assign sweep_new  = sweep_calc(shadow, nr10[3], nr10[2:0]);
   assign sweep_new2 = sweep_calc(sweep_new[10:0], nr10[3], nr10[2:0]);
   assign trig_sweep = sweep_calc(trig_freq, nr10[3], nr10[2:0]);

   // Read-back: write-only bits read as 1. Reads see pre-edge register values.
   always_comb begin
      rd_data = 8'hFF;
      case (sel)
         SEL_NR10: rd_data = {1'b1, nr10};
         SEL_NR11: rd_data = {duty, 6'h3F};
         SEL_NR12: rd_data = nr12;
         SEL_NR13: rd_data = 8'hFF;
         SEL_NR14: rd_data = {1'b1, len_en, 6'h3F};
         default:  rd_data = 8'hFF;
      endcase
   end

   assign rd_en         = I_RESET_L && !I_IOREG_RE_L && (sel != SEL_NONE);
   assign IO_IOREG_DATA = rd_en ? rd_data : 8'hzz;

   always_ff @(posedge I_CLK or negedge I_RESET_L) begin
      if (!I_RESET_L) begin
         nr10        <= 7'd0;
         duty        <= 2'd0;
         nr12        <= 8'd0;
         freq        <= 11'd0;
         len_en      <= 1'b0;
         length_ctr  <= 7'd0;
         volume      <= 4'd0;
         env_timer   <= 3'd0;
         duty_pos    <= 3'd0;
         freq_timer  <= 13'd0;
         shadow      <= 11'd0;
         sweep_timer <= 4'd0;
         sweep_en    <= 1'b0;
         ch_on       <= 1'b0;
         sample      <= 4'd0;
      end else begin
         // Frequency timer: one duty step per (2048 - freq) * 4 clocks.
         if (ch_on) begin
            if (freq_timer == 13'd0) begin
               freq_timer <= freq_reload(freq);
               duty_pos   <= duty_pos + 3'd1;
            end else begin
               freq_timer <= freq_timer - 13'd1;
            end
         end

         // Frame-sequencer units; a trigger this cycle discards their update.
         if (!trigger) begin
            if (len_tick && len_en && (length_ctr != 7'd0)) begin
               length_ctr <= length_ctr - 7'd1;
               if (length_ctr == 7'd1)
                  ch_on <= 1'b0;
            end

            if (env_tick && (nr12[2:0] != 3'd0)) begin
               if (env_timer > 3'd1) begin
                  env_timer <= env_timer - 3'd1;
               end else begin
                  env_timer <= nr12[2:0];
                  if (nr12[3]) begin
                     if (volume != 4'd15)
                        volume <= volume + 4'd1;
                  end else if (volume != 4'd0) begin
                     volume <= volume - 4'd1;
                  end
               end
            end

            if (sweep_tick && ch_on) begin
               if (sweep_timer > 4'd1) begin
                  sweep_timer <= sweep_timer - 4'd1;
               end else begin
                  sweep_timer <= sweep_reload(nr10[6:4]);
                  if (sweep_en && (nr10[6:4] != 3'd0)) begin
                     if (sweep_new > 12'd2047) begin
                        ch_on <= 1'b0;
                     end else if (nr10[2:0] != 3'd0) begin
                        shadow <= sweep_new[10:0];
                        freq   <= sweep_new[10:0];
                        // Look one step ahead with the value just written.
                        if (sweep_new2 > 12'd2047)
                           ch_on <= 1'b0;
                     end
                  end
               end
            end
         end

         // Register writes take priority over unit updates of the same field.
         if (wr_en) begin
            case (sel)
               SEL_NR10: nr10 <= wdata[6:0];
               SEL_NR11: begin
                  duty       <= wdata[7:6];
                  length_ctr <= 7'd64 - {1'b0, wdata[5:0]};
               end
               SEL_NR12: begin
                  nr12 <= wdata;
                  if (~|wdata[7:3])
                     ch_on <= 1'b0;
               end
               SEL_NR13: freq[7:0] <= wdata;
               SEL_NR14: begin
                  len_en     <= wdata[6];
                  freq[10:8] <= wdata[2:0];
               end
               default: ;
            endcase
         end

         if (trigger) begin
            ch_on       <= dac_en && !((nr10[2:0] != 3'd0) && (trig_sweep > 12'd2047));
            if (length_ctr == 7'd0)
               length_ctr <= 7'd64;
            freq_timer  <= freq_reload(trig_freq);
            volume      <= nr12[7:4];
            env_timer   <= nr12[2:0];
            shadow      <= trig_freq;
            sweep_timer <= sweep_reload(nr10[6:4]);
            sweep_en    <= (nr10[6:4] != 3'd0) || (nr10[2:0] != 3'd0);
         end

         sample <= (ch_on && duty_level(duty, duty_pos)) ? volume : 4'd0;
      end
   end

   assign O_CH1_SAMPLE = sample;
   assign O_CH1_ON     = ch_on;

endmodule

// File: tb/tb_sound_ch1_square.sv
// tb/tb_sound_ch1_square.sv - directed self-checking bench for sound_ch1_square

module tb_sound_ch1_square;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] addr;
   logic        we_l;
   logic        re_l;
   logic [7:0]  drv;
   logic        drv_en;
   wire  [7:0]  ioreg_data;
   logic [3:0]  sample;
   logic        ch_on;

   int n_checks = 0;
   int n_errors = 0;
   int cyc;

   assign ioreg_data = drv_en ? drv : 8'hzz;

   // Undriven bus settles to 0x00; no channel register ever reads back as 0x00
   // in these tests, so 0x00 on a read means nobody drove the bus.
   for (genvar g = 0; g < 8; g++) begin : g_pd
      pulldown (ioreg_data[g]);
   end

   always #5 clk = ~clk;

   // Mirrors the frame-sequencer phase: FS_DIV=16 so div = cyc % 16 and
   // step = (cyc / 16) % 8, both counted from reset release.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   sound_ch1_square #(
      .FS_DIV (16),
      .FS_W   (13)
   ) dut (
      .I_CLK         (clk),
      .I_RESET_L     (rst_n),
      .I_IOREG_ADDR  (addr),
      .IO_IOREG_DATA (ioreg_data),
      .I_IOREG_WE_L  (we_l),
      .I_IOREG_RE_L  (re_l),
      .O_CH1_SAMPLE  (sample),
      .O_CH1_ON      (ch_on)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic wr(input logic [15:0] a, input logic [7:0] d);
      addr   = a;
      drv    = d;
      drv_en = 1'b1;
      we_l   = 1'b0;
      @(posedge clk);
      @(negedge clk);
      we_l   = 1'b1;
      drv_en = 1'b0;
      addr   = 16'h0000;
   endtask

   task automatic rd(input logic [15:0] a, output logic [7:0] d);
      addr = a;
      re_l = 1'b0;
      #1;
      d    = ioreg_data;
      re_l = 1'b1;
      addr = 16'h0000;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_cyc(input int n);
      while (cyc < n) @(negedge clk);
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [7:0] d;
      int n;
      int t;

      rst_n  = 1'b0;
      addr   = 16'h0000;
      we_l   = 1'b1;
      re_l   = 1'b1;
      drv    = 8'h00;
      drv_en = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      check_eq("reset_sample", sample, 4'd0);
      check_eq("reset_on", ch_on, 1'b0);
      rd(16'hFF10, d);
      check_eq("reset_bus_z", d, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;

      // Immediate sweep overflow on trigger: 1750 + 875 > 2047
      wr(16'hFF10, 8'hF1);
      wr(16'hFF11, 8'h80);
      wr(16'hFF12, 8'hF7);
      wr(16'hFF13, 8'hD6);
      wr(16'hFF14, 8'h86);
      check_eq("sweep_ovf_on", ch_on, 1'b0);
      @(negedge clk);
      check_eq("sweep_ovf_sample", sample, 4'd0);

      // Register read-back
      rd(16'hFF10, d); check_eq("rd_nr10", d, 8'hF1);
      rd(16'hFF11, d); check_eq("rd_nr11", d, 8'hBF);
      rd(16'hFF12, d); check_eq("rd_nr12", d, 8'hF7);
      rd(16'hFF13, d); check_eq("rd_nr13", d, 8'hFF);
      rd(16'hFF14, d); check_eq("rd_nr14", d, 8'hBF);
      rd(16'hFF15, d); check_eq("rd_other_z", d, 8'h00);

      // Negate sweep does not overflow; period 0 with shift 1 still checks
      do_reset();
      wr(16'hFF10, 8'h09);
      wr(16'hFF12, 8'hF0);
      wr(16'hFF13, 8'hD6);
      wr(16'hFF14, 8'h86);
      check_eq("sweep_neg_on", ch_on, 1'b1);
      wr(16'hFF10, 8'h01);
      wr(16'hFF14, 8'h86);
      check_eq("sweep_p0_ovf_on", ch_on, 1'b0);

      // 440 Hz square, duty 10: 4768 clocks high, 4768 clocks low
      do_reset();
      wr(16'hFF10, 8'h00);
      rd(16'hFF10, d); check_eq("rd_nr10_zero", d, 8'h80);
      wr(16'hFF11, 8'h80);
      wr(16'hFF12, 8'hF0);
      wr(16'hFF13, 8'hD6);
      wr(16'hFF14, 8'h86);
      check_eq("wave_on", ch_on, 1'b1);
      n = 0;
      while (sample != 4'd15 && n < 20000) begin @(negedge clk); n++; end
      n = 0;
      while (sample == 4'd15 && n < 20000) begin @(negedge clk); n++; end
      n = 0;
      while (sample == 4'd0 && n < 20000) begin @(negedge clk); n++; end
      check_eq("wave_low_len", n, 4768);
      n = 0;
      while (sample == 4'd15 && n < 20000) begin @(negedge clk); n++; end
      check_eq("wave_high_len", n, 4768);
      n = 0;
      while (sample == 4'd0 && n < 20000) begin @(negedge clk); n++; end
      check_eq("wave_low_len2", n, 4768);
      check_eq("wave_high_val", sample, 4'd15);

      // Reset mid-note
      rst_n = 1'b0;
      #1;
      check_eq("midreset_sample", sample, 4'd0);
      check_eq("midreset_on", ch_on, 1'b0);
      rd(16'hFF10, d); check_eq("midreset_bus_z", d, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (100) @(negedge clk);
      check_eq("after_reset_on", ch_on, 1'b0);
      rd(16'hFF11, d); check_eq("after_reset_nr11", d, 8'h3F);

      // Envelope down, period 1: one step per 8 frame steps, stops at 0
      do_reset();
      wr(16'hFF11, 8'h40);
      wr(16'hFF12, 8'hF1);
      wr(16'hFF13, 8'h00);
      while (cyc % 128 != 0) @(negedge clk);
      t = cyc;
      wr(16'hFF14, 8'h80);
      wait_cyc(t + 128);  check_eq("env_pre", sample, 4'd15);
      wait_cyc(t + 129);  check_eq("env_step1", sample, 4'd14);
      wait_cyc(t + 257);  check_eq("env_step2", sample, 4'd13);
      wait_cyc(t + 1920); check_eq("env_vol1", sample, 4'd1);
      wait_cyc(t + 1921); check_eq("env_vol0", sample, 4'd0);
      wait_cyc(t + 3000); check_eq("env_no_wrap", sample, 4'd0);
      check_eq("env_still_on", ch_on, 1'b1);
      wr(16'hFF12, 8'h07);
      check_eq("dac_off_on", ch_on, 1'b0);

      // Envelope up saturates at 15
      do_reset();
      wr(16'hFF11, 8'h40);
      wr(16'hFF12, 8'hF9);
      wr(16'hFF13, 8'h00);
      wr(16'hFF14, 8'h80);
      repeat (600) @(negedge clk);
      check_eq("env_sat_hi", sample, 4'd15);

      // Length 2: ticks at cyc_before = 15 mod 32; trigger just after a tick
      do_reset();
      wr(16'hFF12, 8'hF0);
      wr(16'hFF11, 8'h3E);
      while (cyc % 32 != 0) @(negedge clk);
      t = cyc;
      wr(16'hFF14, 8'hC6);
      check_eq("len_on", ch_on, 1'b1);
      wait_cyc(t + 16); check_eq("len_after_tick1", ch_on, 1'b1);
      wait_cyc(t + 47); check_eq("len_before_tick2", ch_on, 1'b1);
      wait_cyc(t + 48); check_eq("len_after_tick2", ch_on, 1'b0);

      // Retrigger with length 0 on a length-tick cycle: reload 64, tick dropped
      while (cyc % 32 != 15) @(negedge clk);
      t = cyc;
      wr(16'hFF14, 8'hC6);
      check_eq("len64_on", ch_on, 1'b1);
      wait_cyc(t + 2048); check_eq("len64_before_end", ch_on, 1'b1);
      wait_cyc(t + 2049); check_eq("len64_end", ch_on, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
